alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of param_alu.
- Accepts one ALU result per cycle (y, Z/N/C/V, op, destination tag) over a valid/ready handshake.
- Buffers results in a DEPTH-entry in-order FIFO for the register-file write port.
- Maintains a last-flags status register, sticky carry/overflow bits and a saturating overflow event counter for software readback.

Parameters:
- W, 8, result data width; matches param_alu W.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 2, destination register tag width.
- CNT_W, 8, overflow event counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result present.
- in_ready  out  1  stage can accept a result this cycle.
- in_op  in  3  ALU opcode that produced the result (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR).
- in_y  in  W  ALU result.
- in_zncv  in  4  ALU flags: [3]=Z, [2]=N, [1]=C, [0]=V.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_y  out  W  head result.
- out_zncv  out  4  head flags.
- out_tag  out  TAG_W  head tag.
- flags_last  out  4  flags of the most recently accepted result.
- sticky_c  out  1  a carry has occurred since the last clear.
- sticky_v  out  1  an overflow has occurred since the last clear.
- ovf_cnt  out  CNT_W  count of accepted overflow events, saturating.
- sticky_clr  in  1  synchronous clear of sticky_c, sticky_v and ovf_cnt.
- count  out  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO pointers, count, flags_last, sticky_c, sticky_v and ovf_cnt all become 0.
  - Consequently out_valid=0 and in_ready=1.
  - out_y, out_zncv and out_tag read 0 while empty after reset.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH) and is registered-state only.
  - It does not depend on out_ready: there is no push-through when full.
  - A push attempted while full is not accepted; upstream must hold in_valid and the data stable until in_ready is high.
- out_valid = (count != 0). out_* is driven combinationally from the head entry.
- Latency: a push into an empty FIFO produces out_valid=1 on the next cycle. There is no same-cycle bypass.
- Pointer and count rules:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Order is strictly FIFO.
  - Pop while empty is impossible by construction (out_valid=0).
- Status update, on push only:
  - flags_last <= in_zncv.
  - arith = (in_op == 000 or in_op == 001).
  - sticky_c is set if arith & in_zncv[1].
  - sticky_v is set if arith & in_zncv[0].
  - ovf_cnt increments if arith & in_zncv[0], saturating at all-ones with no wrap.
  - For logic and shift ops, C and V are ignored for the stickies and the counter; flags_last still captures all four bits.
- sticky_clr:
  - Clears sticky_c, sticky_v and ovf_cnt on the next edge.
  - If a qualifying push occurs in the same cycle, the push wins: the sticky bit is 1 and ovf_cnt becomes 1 (clear, then apply the event).
  - sticky_clr does not affect the FIFO or flags_last.
- in_op values 111 are accepted and stored, and are treated as non-arithmetic.
- Reset asserted mid-operation discards all FIFO contents; no partial entries survive.

Test Plan:
1. Assert rst asynchronously (no clock edge), then release → count=0, in_ready=1, out_valid=0, flags_last=0000, sticky_c=0, sticky_v=0, ovf_cnt=0.
2. Push ADD with y=0x80, zncv=0101, tag=2, out_ready=0 → next cycle out_valid=1, out_y=0x80, out_tag=2, flags_last=0101, sticky_v=1, sticky_c=0, ovf_cnt=1.
3. With out_ready=0, push tags 0,1,2,3 → after the 4th push in_ready=0; a held 5th push (tag 0) is not taken; pop one → in_ready=1 next cycle, the 5th push is then taken, and pops return tags 1,2,3,0 in order.
4. At count=2, push and pop in the same cycle → count stays 2, head advances; then SUB with zncv=0010 → sticky_c=1.
5. Pulse sticky_clr together with a SUB push with zncv=0001 → sticky_v=1, ovf_cnt=1; pulse sticky_clr alone → both 0. Push XOR with zncv=0011 → stickies unchanged, flags_last=0011.
6. Make 300 ADD pushes with V=1 → ovf_cnt=255 (saturated). Assert rst mid-burst with count=3 → count=0, out_valid=0 immediately.

Source files
------------

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: in-order result FIFO plus flag status.
// Status (last flags, sticky C/V, overflow counter) updates only on accepted results.
module alu_wb_stage #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic [W-1:0]                 in_y,
  input  logic [3:0]                   in_zncv,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_y,
  output logic [3:0]                   out_zncv,
  output logic [TAG_W-1:0]             out_tag,
  output logic [3:0]                   flags_last,
  output logic                         sticky_c,
  output logic                         sticky_v,
  output logic [CNT_W-1:0]             ovf_cnt,
  input  logic                         sticky_clr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [W-1:0]     y;
    logic [3:0]       zncv;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [3:0]          flags_q, flags_d;
  logic                sticky_c_q, sticky_c_d;
  logic                sticky_v_q, sticky_v_d;
  logic [CNT_W-1:0]    ovf_q, ovf_d;
  logic [CNT_W-1:0]    ovf_base;
  logic                push, pop, arith;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign arith     = (in_op == 3'b000) || (in_op == 3'b001);

  assign out_y      = mem_q[rd_ptr_q].y;
  assign out_zncv   = mem_q[rd_ptr_q].zncv;
  assign out_tag    = mem_q[rd_ptr_q].tag;
  assign flags_last = flags_q;
  assign sticky_c   = sticky_c_q;
  assign sticky_v   = sticky_v_q;
  assign ovf_cnt    = ovf_q;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    // Clear is applied first so a same-cycle qualifying push still lands.
    sticky_c_d = sticky_clr ? 1'b0 : sticky_c_q;
    sticky_v_d = sticky_clr ? 1'b0 : sticky_v_q;
    ovf_base   = sticky_clr ? '0 : ovf_q;
    ovf_d      = ovf_base;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      flags_d  = in_zncv;
      if (arith && in_zncv[1]) sticky_c_d = 1'b1;
      if (arith && in_zncv[0]) begin
        sticky_v_d = 1'b1;
        if (ovf_base != '1) ovf_d = ovf_base + CNT_W'(1);
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flags_q    <= '0;
      sticky_c_q <= 1'b0;
      sticky_v_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= '{y: in_y, zncv: in_zncv, tag: in_tag};
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      sticky_c_q <= sticky_c_d;
      sticky_v_q <= sticky_v_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - directed testbench for alu_wb_stage.
module tb_alu_wb_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [7:0] in_y = '0;
  logic [3:0] in_zncv = '0;
  logic [1:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
  logic [3:0] out_zncv;
  logic [1:0] out_tag;
  logic [3:0] flags_last;
  logic       sticky_c, sticky_v;
  logic [7:0] ovf_cnt;
  logic       sticky_clr = 1'b0;
  logic [2:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] exp_tag [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] exp_y   [4] = '{8'h11, 8'h21, 8'h31, 8'h55};

  alu_wb_stage #(.W(8), .DEPTH(4), .TAG_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_y(in_y),
    .in_zncv(in_zncv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zncv(out_zncv), .out_tag(out_tag),
    .flags_last(flags_last), .sticky_c(sticky_c), .sticky_v(sticky_v),
    .ovf_cnt(ovf_cnt), .sticky_clr(sticky_clr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_flags", 32'(flags_last), 0);
    chk("rst_sticky_c", 32'(sticky_c), 0);
    chk("rst_sticky_v", 32'(sticky_v), 0);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    chk("rst_out_y", 32'(out_y), 0);
    step();
    rst = 1'b0;

    // 2: ADD push, no bypass, status update
    in_valid = 1'b1; in_op = 3'b000; in_y = 8'h80; in_zncv = 4'b0101; in_tag = 2'd2;
    #1;
    chk("no_bypass", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_out_y", 32'(out_y), 32'h80);
    chk("t2_out_tag", 32'(out_tag), 2);
    chk("t2_out_zncv", 32'(out_zncv), 4'b0101);
    chk("t2_flags", 32'(flags_last), 4'b0101);
    chk("t2_sticky_v", 32'(sticky_v), 1);
    chk("t2_sticky_c", 32'(sticky_c), 0);
    chk("t2_ovf", 32'(ovf_cnt), 1);

    // 3: fill, held push while full, ordering
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("t3_drained", 32'(count), 0);
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1; in_op = 3'b010; in_y = 8'(t * 16 + 1); in_zncv = 4'b0011; in_tag = 2'(t);
      step();
    end
    chk("t3_full_ready", 32'(in_ready), 0);
    chk("t3_full_count", 32'(count), 4);
    chk("t3_logic_no_sticky_c", 32'(sticky_c), 0);
    in_op = 3'b011; in_y = 8'h55; in_zncv = 4'b0000; in_tag = 2'd0;
    step();
    chk("t3_held_count", 32'(count), 4);
    chk("t3_held_flags", 32'(flags_last), 4'b0011);
    chk("t3_head_tag", 32'(out_tag), 0);
    chk("t3_head_y", 32'(out_y), 32'h01);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_pop_count", 32'(count), 3);
    chk("t3_pop_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t3_fifth_count", 32'(count), 4);
    chk("t3_fifth_flags", 32'(flags_last), 4'b0000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order_tag", 32'(out_tag), 32'(exp_tag[i]));
      chk("t3_order_y", 32'(out_y), 32'(exp_y[i]));
      step();
    end
    out_ready = 1'b0;
    chk("t3_empty", 32'(out_valid), 0);

    // 4: simultaneous push/pop at count 2, then SUB carry
    in_valid = 1'b1; in_op = 3'b000; in_zncv = 4'b0000; in_tag = 2'd1; in_y = 8'hA1;
    step();
    in_tag = 2'd2; in_y = 8'hA2;
    step();
    chk("t4_count2", 32'(count), 2);
    in_tag = 2'd3; in_y = 8'hA3; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_pushpop_count", 32'(count), 2);
    chk("t4_head_tag", 32'(out_tag), 2);
    chk("t4_head_y", 32'(out_y), 32'hA2);
    in_op = 3'b001; in_zncv = 4'b0010; in_tag = 2'd0; in_y = 8'h00;
    step();
    in_valid = 1'b0;
    chk("t4_sticky_c", 32'(sticky_c), 1);
    chk("t4_ovf_kept", 32'(ovf_cnt), 1);
    chk("t4_count3", 32'(count), 3);

    // 5: clear vs push priority, clear alone, non-arith ops
    in_valid = 1'b1; in_op = 3'b001; in_zncv = 4'b0001; in_y = 8'h7F; in_tag = 2'd1; sticky_clr = 1'b1;
    step();
    in_valid = 1'b0; sticky_clr = 1'b0;
    chk("t5_clr_push_v", 32'(sticky_v), 1);
    chk("t5_clr_push_ovf", 32'(ovf_cnt), 1);
    chk("t5_clr_push_c", 32'(sticky_c), 0);
    chk("t5_count4", 32'(count), 4);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("t5_clr_v", 32'(sticky_v), 0);
    chk("t5_clr_ovf", 32'(ovf_cnt), 0);
    chk("t5_clr_fifo", 32'(count), 4);
    chk("t5_clr_flags", 32'(flags_last), 4'b0001);
    out_ready = 1'b1;
    repeat (4) step();
    chk("t5_drained", 32'(count), 0);
    in_valid = 1'b1; in_op = 3'b100; in_zncv = 4'b0011; in_y = 8'h3C; in_tag = 2'd3;
    step();
    chk("t5_xor_flags", 32'(flags_last), 4'b0011);
    chk("t5_xor_c", 32'(sticky_c), 0);
    chk("t5_xor_v", 32'(sticky_v), 0);
    chk("t5_xor_ovf", 32'(ovf_cnt), 0);
    in_op = 3'b111; in_zncv = 4'b1011;
    step();
    in_valid = 1'b0;
    chk("t5_op7_flags", 32'(flags_last), 4'b1011);
    chk("t5_op7_v", 32'(sticky_v), 0);
    chk("t5_op7_head", 32'(out_zncv), 4'b1011);
    step();

    // 6: counter saturation, then reset mid-burst
    in_valid = 1'b1; in_op = 3'b000; in_zncv = 4'b0001; in_y = 8'hFF; in_tag = 2'd0;
    repeat (254) step();
    chk("t6_ovf254", 32'(ovf_cnt), 254);
    step();
    chk("t6_ovf255", 32'(ovf_cnt), 255);
    repeat (45) step();
    chk("t6_ovf_sat", 32'(ovf_cnt), 255);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b010; in_zncv = 4'b0000;
    repeat (3) step();
    chk("t6_count3", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    chk("t6_rst_ovf", 32'(ovf_cnt), 0);
    chk("t6_rst_out_y", 32'(out_y), 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_y = 8'h42; in_tag = 2'd1;
    step();
    in_valid = 1'b0;
    chk("t6_post_count", 32'(count), 1);
    chk("t6_post_y", 32'(out_y), 32'h42);
    chk("t6_post_tag", 32'(out_tag), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
